// File: rtl/spi_reg_pkg.sv
// +------------------------------------------------------------------------+
// | Package     : spi_reg_pkg                                              |
// | Description : Shared constants, frame field positions and FSM state    |
// |               encoding for the SPI register peripheral.                |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
`default_nettype none

package spi_reg_pkg;

  // Register addresses; also used as register-bank indices
  localparam int ADDR_EN_OUT_LO  = 'h00;
  localparam int ADDR_EN_OUT_HI  = 'h01;
  localparam int ADDR_EN_PWM_LO  = 'h02;
  localparam int ADDR_EN_PWM_HI  = 'h03;
  localparam int ADDR_PWM_DUTY   = 'h04;

  // Frame layout, MSB first on the wire
  localparam int FRAME_BITS = 16;
  localparam int RW_BIT     = 15;
  localparam int ADDR_MSB   = 14;
  localparam int ADDR_LSB   = 8;
  localparam int DATA_MSB   = 7;
  localparam int DATA_LSB   = 0;

  // Bit counter: saturating, so 17 marks "too many bits"
  localparam int         CNT_W     = 5;
  localparam logic [4:0] CNT_FRAME = 5'd16;
  localparam logic [4:0] CNT_MAX   = 5'd17;
  localparam logic [4:0] CNT_HDR   = 5'd7;   // bits seen before the last header bit

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// +------------------------------------------------------------------------+
// | Module      : spi_sync_edge                                            |
// | Description : Multi-flop synchronizer for one asynchronous pin plus    |
// |               rise/fall detection against one extra flop.              |
// | Ports       : clk, rst    - clock, async active-high reset             |
// |               d_i         - asynchronous pin                           |
// |               q_o         - synchronized level                         |
// |               rise_o/fall_o - single-clk edge pulses aligned with q_o  |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
`default_nettype none

module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,     // must be >= 2
  parameter logic RST_VAL     = 1'b0   // idle level of the pin
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Resetting to the idle level keeps a reset from fabricating an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

`default_nettype wire

// File: rtl/spi_reg_peripheral.sv
// +------------------------------------------------------------------------+
// | Module      : spi_reg_peripheral                                       |
// | Description : SPI mode-0 slave decoding 16-bit frames into five 8-bit  |
// |               control registers (output/PWM enables, duty cycle).     |
// | Ports       : clk, rst           - system clock, async active-high rst |
// |               sclk, copi, ncs    - SPI pins, asynchronous to clk      |
// |               cipo               - readback data (0 when disabled)    |
// |               en_reg_*, pwm_duty_cycle - register bank outputs        |
// |               wr_strobe          - 1-clk pulse on register write      |
// |               frame_err          - 1-clk pulse on discarded frame     |
// | Config      : define SPI_READBACK_EN to enable register readback      |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
`default_nettype none

module spi_reg_peripheral
  import spi_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic       frame_err
);

  // ---------------------------------------------------------------------
  // Pin synchronizers
  // ---------------------------------------------------------------------
  logic w_sclk_q, w_sclk_rise, w_sclk_fall;
  logic w_copi, w_copi_rise, w_copi_fall;
  logic w_ncs, w_ncs_rise, w_ncs_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d_i(sclk),
    .q_o(w_sclk_q), .rise_o(w_sclk_rise), .fall_o(w_sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .d_i(copi),
    .q_o(w_copi), .rise_o(w_copi_rise), .fall_o(w_copi_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .d_i(ncs),
    .q_o(w_ncs), .rise_o(w_ncs_rise), .fall_o(w_ncs_fall)
  );

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic            pend_q, pend_d;     // ncs fell while in COMMIT
  logic [7:0]      regs_q [NUM_REGS];
  logic [7:0]      regs_d [NUM_REGS];
  logic            wr_strobe_q, wr_strobe_d;
  logic            frame_err_q, frame_err_d;

  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_data;
  logic              w_rw;
  logic              w_addr_ok;

  assign w_rw      = shift_q[RW_BIT];
  assign w_addr    = shift_q[ADDR_MSB:ADDR_LSB];
  assign w_data    = shift_q[DATA_MSB:DATA_LSB];
  assign w_addr_ok = ({1'b0, w_addr} < (ADDR_W+1)'(NUM_REGS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      pend_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      pend_q      <= pend_d;
      wr_strobe_q <= wr_strobe_d;
      frame_err_q <= frame_err_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    pend_d      = pend_q;
    wr_strobe_d = 1'b0;
    frame_err_d = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];

    case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        // A deferred fall only counts if the line is still low
        if (w_ncs_fall || (pend_q && !w_ncs)) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shift_d = '0;
        end
      end

      SHIFT: begin
        // ncs rise takes priority over a coincident sclk rise
        if (w_ncs_rise) begin
          state_d = COMMIT;
        end else if (w_sclk_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], w_copi};
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end
      end

      COMMIT: begin
        state_d = IDLE;
        if (w_ncs_fall) pend_d = 1'b1;
        if (cnt_q == CNT_FRAME && w_addr_ok) begin
          if (w_rw) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (w_addr == ADDR_W'(i)) regs_d[i] = w_data;
            end
            wr_strobe_d = 1'b1;
          end else begin
`ifdef SPI_READBACK_EN
            frame_err_d = 1'b0;   // valid read: nothing to commit
`else
            frame_err_d = 1'b1;
`endif
          end
        end else begin
          frame_err_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Optional readback shifter
  // ---------------------------------------------------------------------
`ifdef SPI_READBACK_EN
  logic [7:0]        oshift_q, oshift_d;
  logic              cipo_q, cipo_d;
  logic [ADDR_W-1:0] w_hdr_addr;
  logic              w_hdr_rw;
  logic [7:0]        w_rd_data;

  // On the 8th sclk rise the header is shift_q[6:0] plus the incoming bit
  assign w_hdr_rw   = shift_q[6];
  assign w_hdr_addr = {shift_q[5:0], w_copi};

  always_comb begin
    w_rd_data = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_hdr_addr == ADDR_W'(i)) w_rd_data = regs_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oshift_q <= 8'h00;
      cipo_q   <= 1'b0;
    end else begin
      oshift_q <= oshift_d;
      cipo_q   <= cipo_d;
    end
  end

  always_comb begin
    oshift_d = oshift_q;
    cipo_d   = cipo_q;
    if (w_ncs) begin
      oshift_d = 8'h00;
      cipo_d   = 1'b0;
    end else if (state_q == SHIFT && w_sclk_rise && !w_ncs_rise && cnt_q == CNT_HDR) begin
      // Out-of-range or write headers shift out zeros
      oshift_d = w_hdr_rw ? 8'h00 : w_rd_data;
    end else if (w_sclk_fall) begin
      cipo_d   = oshift_q[7];
      oshift_d = {oshift_q[6:0], 1'b0};
    end
  end

  assign cipo = cipo_q;

  logic w_unused_pins;
  assign w_unused_pins = &{w_sclk_q, w_copi_rise, w_copi_fall};
`else
  assign cipo = 1'b0;

  logic w_unused_pins;
  assign w_unused_pins = &{w_sclk_q, w_sclk_fall, w_copi_rise, w_copi_fall};
`endif

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_LO];
  assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_HI];
  assign en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_LO];
  assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_HI];
  assign pwm_duty_cycle  = regs_q[ADDR_PWM_DUTY];
  assign wr_strobe       = wr_strobe_q;
  assign frame_err       = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_peripheral.sv
// +------------------------------------------------------------------------+
// | Module      : tb_spi_reg_peripheral                                    |
// | Description : Self-checking bench for spi_reg_peripheral: frame-level |
// |               register model, per-cycle compare, directed frames.     |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_spi_reg_peripheral;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic       ncs  = 1'b1;
  logic       cipo;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       wr_strobe, frame_err;

  spi_reg_peripheral dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int         n_pass = 0;
  int         n_total = 0;
  logic [7:0] exp_regs [5];
  bit         in_window = 1'b1;   // outputs allowed to change; per-cycle compare paused

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [39:0] dut_regs();
    return {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle};
  endfunction

  function automatic logic [39:0] model_regs();
    return {exp_regs[0], exp_regs[1], exp_regs[2], exp_regs[3], exp_regs[4]};
  endfunction

  // Outside commit windows nothing may change and no pulses may appear
  always @(negedge clk) begin
    if (!in_window) begin
      check("steady", {dut_regs(), wr_strobe, frame_err, (ncs & cipo)},
                      {model_regs(), 3'b000});
    end
  end

  // Frame-level model: 0 = silent, 1 = write, 2 = frame error
  function automatic int model_kind(input logic [31:0] bits, input int nbits);
    logic [6:0] a;
    a = bits[14:8];
    if (nbits != 16 || a >= 7'd5) return 2;
    if (bits[15]) return 1;
`ifdef SPI_READBACK_EN
    return 0;
`else
    return 2;
`endif
  endfunction

  task automatic shift_bits(input logic [31:0] bits, input int nbits, inout logic [15:0] cap);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = bits[i];
      #40;
      cap  = {cap[14:0], cipo};
      sclk = 1'b1;
      #40;
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input string name, input logic [31:0] bits, input int nbits,
                       output logic [15:0] cap);
    int kind;
    int k;
    cap  = 16'h0000;
    ncs  = 1'b0;
    #80;
    shift_bits(bits, nbits, cap);
    #40;
    kind = model_kind(bits, nbits);
    in_window = 1'b1;
    ncs = 1'b1;
    for (k = 0; k < 12; k++) begin
      @(negedge clk);
      if (wr_strobe || frame_err) break;
    end
    if (kind == 1) exp_regs[bits[10:8]] = bits[7:0];
    check({name, "_pulse"}, {wr_strobe, frame_err}, {kind == 1, kind == 2});
    check({name, "_regs"}, dut_regs(), model_regs());
    if (kind != 0) check({name, "_latency"}, (k <= 3), 1'b1);
    @(negedge clk);
    in_window = 1'b0;
    #3;
  endtask

  logic [15:0] cap;

  initial begin
    for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
    #3;
    repeat (3) @(negedge clk);
    check("reset_state", {dut_regs(), cipo, wr_strobe, frame_err}, 43'h0);
    #3 rst = 1'b0;
    @(negedge clk);
    in_window = 1'b0;
    #3;

    frame("w_duty", 32'h8480, 16, cap);
    check("lit_duty_80", {pwm_duty_cycle, en_reg_out_7_0}, 16'h8000);

    frame("w_r0", 32'h80FF, 16, cap);
    frame("w_r1", 32'h81AA, 16, cap);
    frame("w_r2", 32'h8255, 16, cap);
    frame("w_r3", 32'h8301, 16, cap);
    check("lit_regs", dut_regs(), 40'hFF_AA_55_01_80);

    // Stray sclk while deselected must be ignored
    repeat (3) begin
      #40 sclk = 1'b1;
      #40 sclk = 1'b0;
    end
    #20;

    frame("short15", 32'h4009, 15, cap);     // first 15 bits of 0x8012
    frame("long17", 32'h10024, 17, cap);     // 0x8012 plus one extra bit
    check("lit_r0_kept", en_reg_out_7_0, 8'hFF);

    frame("bad_addr", 32'h8533, 16, cap);
    check("lit_after_bad", dut_regs(), 40'hFF_AA_55_01_80);

    // Reset in the middle of a frame
    ncs = 1'b0;
    #80;
    shift_bits(32'h8433 >> 7, 9, cap);
    in_window = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
    @(negedge clk);
    check("mid_rst", {dut_regs(), wr_strobe, frame_err}, 42'h0);
    #3 ncs = 1'b1;
    #40 rst = 1'b0;
    repeat (4) @(negedge clk);
    in_window = 1'b0;
    #3;
    check("lit_duty_00", pwm_duty_cycle, 8'h00);

    frame("w_duty2", 32'h8411, 16, cap);
    check("lit_duty_11", dut_regs(), 40'h00_00_00_00_11);

`ifdef SPI_READBACK_EN
    frame("w_5a", 32'h845A, 16, cap);
    frame("rd_duty", 32'h0400, 16, cap);
    check("readback", cap[7:0], 8'h5A);
    frame("rd_bad", 32'h0700, 16, cap);
    check("readback_bad", cap[7:0], 8'h00);
`else
    frame("rd_duty", 32'h0400, 16, cap);
    check("lit_read_kept", pwm_duty_cycle, 8'h11);
`endif

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
